// File: rtl/cbus_responder_pkg.sv
// Shared cbus package: request/response structs, burst and length encodings.
package cbus_responder_pkg;

  localparam int CBUS_ADDR_BITS = 32;
  localparam int CBUS_DATA_BITS = 32;
  localparam int CBUS_STRB_BITS = CBUS_DATA_BITS / 8;
  localparam int CBUS_LEN_BITS  = 4;

  // Burst type: FIXED repeats one word, INCR walks through consecutive words
  typedef enum logic {
    BURST_FIXED = 1'b0,
    BURST_INCR  = 1'b1
  } cbus_burst_e;

  // Transfer size hint carried by the bus
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } cbus_size_e;

  // Burst length encoded as number of beats minus one
  typedef logic [CBUS_LEN_BITS-1:0] cbus_len_t;

  typedef struct packed {
    logic                        valid;
    logic                        is_write;
    cbus_size_e                  size;
    logic [CBUS_ADDR_BITS-1:0]   addr;
    logic [CBUS_STRB_BITS-1:0]   strobe;
    logic [CBUS_DATA_BITS-1:0]   data;
    cbus_len_t                   len;
    cbus_burst_e                 burst;
  } cbus_req_t;

  typedef struct packed {
    logic                        ready;
    logic                        last;
    logic [CBUS_DATA_BITS-1:0]   data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_responder_mem.sv
// Word-organised backing store: one asynchronous read port and one
// synchronous byte-enabled write port. Contents are never reset.
module cbus_responder_mem
  import cbus_responder_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [CBUS_STRB_BITS-1:0] be,
  input  logic [ADDR_BITS-1:0]      waddr,
  input  logic [CBUS_DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0]      raddr,
  output logic [CBUS_DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [CBUS_DATA_BITS-1:0] mem [DEPTH];

  // Commit only the enabled byte lanes of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < CBUS_STRB_BITS; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cbus_responder.sv
// cbus memory model: accepts one request, waits LATENCY cycles, then
// serves len+1 beats (FIXED or INCR with wrap) against the backing store.
module cbus_responder
  import cbus_responder_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_e                    state;
  logic [3:0]                beat_cnt;
  logic [3:0]                lat_cnt;
  logic [ADDR_BITS-1:0]      idx;
  logic                      beat_ready;
  logic                      beat_last;
  logic                      mem_we;
  logic [CBUS_DATA_BITS-1:0] rd_data;
  logic                      unused_req_bits;

  // A beat happens whenever the burst phase sees a valid request
  assign beat_ready = (state == ST_BURST) && creq.valid;
  assign beat_last  = beat_ready && (beat_cnt == creq.len);
  assign mem_we     = beat_ready && creq.is_write;

  // Size and the address bits outside the word index carry no meaning here
  assign unused_req_bits = ^{creq.size, creq.addr};

  // Response is zero outside of beats so idle cycles never leak read data
  always_comb begin
    cresp       = '0;
    cresp.ready = beat_ready;
    cresp.last  = beat_last;
    cresp.data  = beat_ready ? rd_data : '0;
  end

  // Transaction sequencing: accept, latency countdown, beat stream
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      idx      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (creq.valid) begin
            idx      <= creq.addr[ADDR_BITS+1:2];
            beat_cnt <= '0;
            lat_cnt  <= LAT_LOAD;
            state    <= (LATENCY == 0) ? ST_BURST : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!creq.valid) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
          end else if (lat_cnt <= 4'd1) begin
            lat_cnt <= '0;
            state   <= ST_BURST;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_BURST: begin
          if (!creq.valid || beat_last) begin
            state <= ST_IDLE;
          end else begin
            beat_cnt <= beat_cnt + 4'd1;
            if (creq.burst == BURST_INCR) begin
              idx <= idx + ADDR_BITS'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  cbus_responder_mem #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (creq.strobe),
    .waddr (idx),
    .wdata (creq.data),
    .raddr (idx),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_cbus_responder.sv
// Bench for cbus_responder: directed scenarios followed by random traffic,
// checked against a word/byte-lane reference memory kept in the bench.
module tb_cbus_responder;
  import cbus_responder_pkg::*;

  localparam int ADDR_BITS = 12;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  known   [DEPTH];
  logic [31:0] wbuf    [16];
  logic [31:0] rbuf    [16];

  cbus_responder #(
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .creq   (creq),
    .cresp  (cresp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net in case the run never reaches its summary
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] byte_mask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; entered and left just after a rising edge.
  // reset_beat >= 0 pulls resetn low in the middle of that beat.
  task automatic apply_stimulus(input bit wr, input logic [31:0] addr, input int len,
                                input bit incr, input logic [3:0] strb, input int reset_beat);
    int base;
    base = int'((addr >> 2) % DEPTH);
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = cbus_size_e'($urandom_range(0, 3));
    creq.addr     = addr;
    creq.strobe   = strb;
    creq.len      = 4'(len);
    creq.burst    = incr ? BURST_INCR : BURST_FIXED;
    creq.data     = wbuf[0];
    for (int c = 0; c <= LATENCY; c++) begin
      @(negedge clk);
      check_output("no_ready_before_latency", 32'(cresp.ready), 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k <= len; k++) begin
      int idx;
      logic [31:0] m;
      idx = incr ? (base + k) % DEPTH : base;
      creq.data = wbuf[k];
      @(negedge clk);
      check_output("beat_ready", 32'(cresp.ready), 32'd1);
      check_output("beat_last", 32'(cresp.last), 32'(k == len));
      if (!wr) begin
        rbuf[k] = cresp.data;
        m = byte_mask(known[idx]);
        if (m != 32'd0) check_output("read_data", cresp.data & m, ref_mem[idx] & m);
      end
      if (k == reset_beat) begin
        #1 resetn = 1'b0;
        #1;
        check_output("reset_ready", 32'(cresp.ready), 32'd0);
        check_output("reset_last", 32'(cresp.last), 32'd0);
        check_output("reset_data", cresp.data, 32'd0);
        @(posedge clk); #1;
        resetn     = 1'b1;
        creq.valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk);
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (strb[i]) begin
            ref_mem[idx][8*i +: 8] = wbuf[k][8*i +: 8];
            known[idx][i] = 1'b1;
          end
        end
      end
      #1;
    end
    @(negedge clk);
    check_output("idle_gap_no_ready", 32'(cresp.ready), 32'd0);
    @(posedge clk); #1;
    creq.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known[i]   = 4'h0;
      ref_mem[i] = 32'h0;
    end
    creq   = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.strobe   = 4'hF;
    @(negedge clk);
    check_output("rst_ready", 32'(cresp.ready), 32'd0);
    check_output("rst_last", 32'(cresp.last), 32'd0);
    check_output("rst_data", cresp.data, 32'd0);
    @(posedge clk); #1;
    creq   = '0;
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single write then read");
    wbuf[0] = 32'hDEADBEEF;
    apply_stimulus(1'b1, 32'h100, 0, 1'b1, 4'hF, -1);
    apply_stimulus(1'b0, 32'h100, 0, 1'b1, 4'hF, -1);
    check_output("single_rw", rbuf[0], 32'hDEADBEEF);

    $display("[TB] partial strobe");
    wbuf[0] = 32'h11223344;
    apply_stimulus(1'b1, 32'h104, 0, 1'b1, 4'hF, -1);
    wbuf[0] = 32'hAABBCCDD;
    apply_stimulus(1'b1, 32'h104, 0, 1'b1, 4'b0101, -1);
    apply_stimulus(1'b0, 32'h104, 0, 1'b1, 4'hF, -1);
    check_output("partial_strobe", rbuf[0], 32'h11BB33DD);

    $display("[TB] 16-beat INCR burst");
    for (int k = 0; k < 16; k++) wbuf[k] = 32'(k);
    apply_stimulus(1'b1, 32'h200, 15, 1'b1, 4'hF, -1);
    apply_stimulus(1'b0, 32'h200, 15, 1'b1, 4'hF, -1);
    for (int k = 0; k < 16; k++) check_output("incr16_data", rbuf[k], 32'(k));

    $display("[TB] wrap-around and FIXED");
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
    apply_stimulus(1'b1, 32'h3FFC, 3, 1'b1, 4'hF, -1);
    apply_stimulus(1'b0, 32'h0, 0, 1'b1, 4'hF, -1);
    check_output("wrap_index0", rbuf[0], 32'hA1);
    apply_stimulus(1'b0, 32'h3FFC, 0, 1'b1, 4'hF, -1);
    check_output("wrap_index4095", rbuf[0], 32'hA0);
    for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
    apply_stimulus(1'b1, 32'h40, 3, 1'b0, 4'hF, -1);
    apply_stimulus(1'b0, 32'h40, 0, 1'b1, 4'hF, -1);
    check_output("fixed_last_wins", rbuf[0], 32'd4);

    $display("[TB] reset in the middle of a burst");
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h50000000 + 32'(k);
    apply_stimulus(1'b1, 32'h300, 7, 1'b1, 4'hF, -1);
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h60000000 + 32'(k);
    apply_stimulus(1'b1, 32'h300, 7, 1'b1, 4'hF, 3);
    apply_stimulus(1'b0, 32'h300, 7, 1'b1, 4'hF, -1);
    for (int k = 0; k < 8; k++)
      check_output("reset_retain", rbuf[k], (k < 3) ? 32'h60000000 + 32'(k) : 32'h50000000 + 32'(k));

    $display("[TB] abort during wait");
    wbuf[0] = 32'h12345678;
    apply_stimulus(1'b1, 32'h400, 0, 1'b1, 4'hF, -1);
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.addr     = 32'h400;
    creq.strobe   = 4'hF;
    creq.data     = 32'hFFFFFFFF;
    creq.burst    = BURST_INCR;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("abort_no_ready", 32'(cresp.ready), 32'd0);
      @(posedge clk); #1;
      if (c == 1) creq.valid = 1'b0;
    end
    apply_stimulus(1'b0, 32'h400, 0, 1'b1, 4'hF, -1);
    check_output("abort_no_write", rbuf[0], 32'h12345678);

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      int base;
      logic [31:0] addr;
      base = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, 31);
      addr = ($urandom & 32'hFFFFC000) | 32'(base << 2) | 32'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
      apply_stimulus(1'($urandom_range(0, 1)), addr, $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbus_responder.md
CBUS_RESPONDER -- requirements
Module: cbus_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning the backing store holds 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and the first data beat (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port creq  input  cbus_req_t  request from one cbus initiator: valid, is_write, size, addr[31:0], strobe[3:0], data[31:0], len (beats-1, 4 bits), burst (FIXED/INCR).
REQ-006 SHALL have port cresp  output  cbus_resp_t  response: ready, last, data[31:0].

Function
REQ-007 SHALL implement states IDLE, WAIT and BURST, plus a beat counter (4 bits) and a latency counter (4 bits).
REQ-008 IDLE: creq.valid=1 SHALL latch the word index addr[ADDR_BITS+1:2], clear the beat counter, load the latency counter with LATENCY, and go to WAIT (or to BURST when LATENCY=0).
REQ-009 WAIT: the latency counter SHALL decrement each cycle, and the block SHALL enter BURST on the cycle after it reaches 0.
REQ-010 cresp.ready SHALL be 1 exactly when state is BURST and creq.valid=1, giving one beat per cycle with no bubbles.
REQ-011 cresp.last SHALL equal cresp.ready AND (beat counter == creq.len).
REQ-012 Read beat: cresp.data SHALL be the combinational mem[current index]; when ready=0, cresp.data SHALL be 0.
REQ-013 Write beat: each byte i of mem[current index] whose creq.strobe[i]=1 SHALL take creq.data[8i+7:8i] at the clock edge where ready=1; strobe=0 SHALL write nothing.
REQ-014 After each beat, INCR SHALL advance the index by 1 modulo 2^ADDR_BITS (wrap-around), and FIXED SHALL keep the index unchanged.
REQ-015 The beat where last=1 SHALL return the block to IDLE; the block SHALL spend at least one IDLE cycle between transactions, so no back-to-back acceptance.
REQ-016 creq.valid dropping in WAIT or BURST (protocol violation) SHALL abort to IDLE next cycle with no further writes.
REQ-017 Address bits above ADDR_BITS+1 and creq.size SHALL be ignored; sub-word access is expressed only through strobe.
REQ-018 len=0 SHALL give a single beat with last=1 on that beat.

Reset
REQ-019 resetn=0 SHALL immediately force state IDLE, counters 0, cresp.ready=0, cresp.last=0, cresp.data=0, including mid-burst.
REQ-020 Memory contents SHALL NOT be cleared by reset; writes already committed before reset SHALL persist.

Structure
REQ-021 cbus_req_t, cbus_resp_t, the burst encodings and the len encoding SHALL come from the existing shared bus package; this block SHALL add only a local state enum.
REQ-022 Storage SHALL be one sub-module, cbus_responder_mem, providing 1 async read port, 1 sync byte-enabled write port and 2^ADDR_BITS x 32 bits.
REQ-023 The block SHALL be a simulation/FPGA memory model usable directly on VTop's oreq/oresp.

Verification
REQ-024 Single write then read: write addr 0x100, data 0xDEADBEEF, strobe 4'hF, len 0 -> ready after LATENCY+1 cycles with last=1; a later read of 0x100 returns 0xDEADBEEF.
REQ-025 Partial strobe: write 0x11223344 to 0x104, then 0xAABBCCDD with strobe 4'b0101 -> read returns 0x11BB33DD.
REQ-026 INCR burst read: preload 0x200..0x23C with values 0..15, then read len 15 INCR -> 16 consecutive ready beats with data 0..15, last only on beat 16, then IDLE.
REQ-027 Wrap and FIXED: INCR len 3 at the last word (ADDR_BITS=12, addr 0x3FFC) -> beats hit indices 4095,0,1,2; FIXED len 3 write 1,2,3,4 at 0x40 -> mem[0x40/4]=4.
REQ-028 Reset mid-burst: assert resetn=0 on beat 3 of an 8-beat write -> ready/last drop the same cycle, beats 0-2 are retained, beats 3+ are not written, and the next request is served normally.
REQ-029 Abort: drop valid during WAIT -> no ready pulse, state IDLE next cycle.
